// File: rtl/perip_bridge_if.sv
// Core data port plus DRAM pass-through signals seen by the peripheral bridge.
interface perip_bridge_if;
   logic [31:0] perip_addr;
   logic        perip_wen;
   logic [1:0]  perip_mask;
   logic [31:0] perip_wdata;
   logic [31:0] perip_rdata;
   logic [31:0] dram_addr;
   logic        dram_wen;
   logic [1:0]  dram_mask;
   logic [31:0] dram_wdata;
   logic [31:0] dram_rdata;

   // Bridge side
   modport slave (
      input  perip_addr, perip_wen, perip_mask, perip_wdata, dram_rdata,
      output perip_rdata, dram_addr, dram_wen, dram_mask, dram_wdata
   );

   // Core / DRAM side
   modport master (
      output perip_addr, perip_wen, perip_mask, perip_wdata, dram_rdata,
      input  perip_rdata, dram_addr, dram_wen, dram_mask, dram_wdata
   );
endinterface

// File: rtl/perip_bridge.sv
// Peripheral bridge: decodes core data accesses to DRAM pass-through or MMIO
// (UART TX with FIFO, 64-bit cycle timer, 16-bit LED register).
module perip_bridge #(
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'h8020_0000,
   parameter logic [31:0] DRAM_BASE  = 32'h8010_0000
) (
   input  logic           cpu_clk,
   input  logic           cpu_rst,
   perip_bridge_if.slave  bus,
   output logic           uart_tx,
   output logic [15:0]    led
);

   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [2:0] REG_TXDATA   = 3'd0;
   localparam logic [2:0] REG_STATUS   = 3'd1;
   localparam logic [2:0] REG_TIMER_LO = 3'd2;
   localparam logic [2:0] REG_TIMER_HI = 3'd3;
   localparam logic [2:0] REG_LED      = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_e;

   // State
   state_e              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [2:0]          bit_q, bit_d;
   logic [7:0]          shift_q, shift_d;
   logic                tx_q, tx_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                ovf_q, ovf_d;
   logic [15:0]         led_q, led_d;
   logic [63:0]         timer_q, timer_d;
   logic [7:0]          mem_q [FIFO_DEPTH];

   // Combinational helpers
   logic        sel_dram_c;
   logic        sel_mmio_c;
   logic [2:0]  reg_sel_c;
   logic        mmio_we_c;
   logic        fifo_empty_c;
   logic        fifo_full_c;
   logic        busy_c;
   logic        push_req_c;
   logic        push_c;
   logic        pop_c;
   logic        baud_last_c;
   logic [31:0] mmio_rdata_c;
   logic [31:0] rdata_c;

   // Address decode; DRAM window takes priority should the windows ever overlap
   always_comb begin
      sel_dram_c = (bus.perip_addr[31:20] == DRAM_BASE[31:20]);
      sel_mmio_c = (bus.perip_addr[31:20] == MMIO_BASE[31:20]) && !sel_dram_c;
      reg_sel_c  = bus.perip_addr[4:2];
      mmio_we_c  = bus.perip_wen && sel_mmio_c;
   end

   assign bus.dram_addr  = bus.perip_addr;
   assign bus.dram_mask  = bus.perip_mask;
   assign bus.dram_wdata = bus.perip_wdata;
   assign bus.dram_wen   = bus.perip_wen && sel_dram_c && cpu_rst;

   always_comb begin
      fifo_empty_c = (count_q == '0);
      fifo_full_c  = (count_q == CNT_W'(FIFO_DEPTH));
      busy_c       = !fifo_empty_c || (state_q != ST_IDLE);
      push_req_c   = mmio_we_c && (reg_sel_c == REG_TXDATA);
      push_c       = push_req_c && !fifo_full_c;
      baud_last_c  = (baud_q == BAUD_W'(CLK_DIV - 1));
   end

   // Side-effect-free read mux
   always_comb begin
      mmio_rdata_c = '0;
      case (reg_sel_c)
         REG_STATUS:   mmio_rdata_c = {28'd0, busy_c, ovf_q, fifo_full_c, fifo_empty_c};
         REG_TIMER_LO: mmio_rdata_c = timer_q[31:0];
         REG_TIMER_HI: mmio_rdata_c = timer_q[63:32];
         REG_LED:      mmio_rdata_c = {16'd0, led_q};
         default:      mmio_rdata_c = '0;
      endcase
      rdata_c = '0;
      if (sel_dram_c) begin
         rdata_c = bus.dram_rdata;
      end else if (sel_mmio_c) begin
         rdata_c = mmio_rdata_c;
      end
   end

   assign bus.perip_rdata = rdata_c;

   // FIFO bookkeeping, overflow sticky, LED and timer next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      led_d    = led_q;
      timer_d  = timer_q + 64'd1;

      if (push_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (push_req_c && fifo_full_c) begin
         ovf_d = 1'b1;
      end else if (mmio_we_c && (reg_sel_c == REG_STATUS) && bus.perip_wdata[2]) begin
         ovf_d = 1'b0;
      end

      if (mmio_we_c && (reg_sel_c == REG_LED)) begin
         if (bus.perip_mask == 2'b00) begin
            led_d = {led_q[15:8], bus.perip_wdata[7:0]};
         end else begin
            led_d = bus.perip_wdata[15:0];
         end
      end
   end

   // Serializer next-state; tx is registered from the state being entered
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop_c   = 1'b0;
      tx_d    = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty_c) begin
               pop_c   = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               baud_d  = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (baud_last_c) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            if (baud_last_c) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_STOP: begin
            if (baud_last_c) begin
               baud_d = '0;
               // Back-to-back frame: skip IDLE when more data is waiting
               if (!fifo_empty_c) begin
                  pop_c   = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_START) begin
         tx_d = 1'b0;
      end else if (state_d == ST_DATA) begin
         tx_d = shift_d[0];
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         led_q    <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         led_q    <= led_d;
         timer_q  <= timer_d;
      end
   end

   // FIFO storage needs no reset; the pointers define what is valid
   always_ff @(posedge cpu_clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= bus.perip_wdata[7:0];
      end
   end

   assign uart_tx = tx_q;
   assign led     = led_q;

endmodule

// File: tb/tb_perip_bridge.sv
// Directed bench for perip_bridge: decode, MMIO registers, UART framing, FIFO overflow.
module tb_perip_bridge;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned FRAME   = 10 * CLK_DIV;

   localparam logic [31:0] A_TXDATA = 32'h8020_0000;
   localparam logic [31:0] A_STATUS = 32'h8020_0004;
   localparam logic [31:0] A_TLO    = 32'h8020_0008;
   localparam logic [31:0] A_THI    = 32'h8020_000C;
   localparam logic [31:0] A_LED    = 32'h8020_0010;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        uart_tx;
   logic [15:0] led;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] ta, tb_v;

   perip_bridge_if bus ();

   perip_bridge #(
      .CLK_DIV   (CLK_DIV),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .cpu_clk(clk),
      .cpu_rst(rst_n),
      .bus    (bus.slave),
      .uart_tx(uart_tx),
      .led    (led)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.perip_wen  = 1'b0;
      bus.perip_addr = a;
      #1;
      d = bus.perip_rdata;
   endtask

   task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      chk(tag, 64'(d), 64'(exp));
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
      bus.perip_addr  = a;
      bus.perip_wdata = d;
      bus.perip_mask  = m;
      bus.perip_wen   = 1'b1;
      tick();
      bus.perip_wen   = 1'b0;
   endtask

   // Expected line level at cycle c of an 8N1 frame carrying byte b
   function automatic logic frame_bit(input logic [7:0] b, input int unsigned c);
      int unsigned slot;
      slot = c / CLK_DIV;
      if (slot == 0) return 1'b0;
      if (slot >= 9) return 1'b1;
      return b[slot-1];
   endfunction

   // Stream of back-to-back frames carrying bytes 0,1,2,...
   function automatic logic stream_bit(input int unsigned c);
      return frame_bit(8'(c / FRAME), c % FRAME);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired, vectors=%0d miscompares=%0d", n_vec, n_err);
      $fatal(1, "timeout");
   end

   initial begin
      bus.perip_addr  = 32'h0;
      bus.perip_wen   = 1'b0;
      bus.perip_mask  = 2'b10;
      bus.perip_wdata = 32'h0;
      bus.dram_rdata  = 32'h0;

      // Reset
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_uart_tx", 64'(uart_tx), 64'd1);
      chk("rst_led", 64'(led), 64'h0);
      chk_rd("rst_status", A_STATUS, 32'h0000_0001);
      rst_n = 1'b1;

      // Timer starts at 0 and advances one per cycle
      chk_rd("timer_first", A_TLO, 32'd0);
      tick();
      chk_rd("timer_second", A_TLO, 32'd1);
      rd(A_TLO, ta);
      repeat (5) tick();
      rd(A_TLO, tb_v);
      chk("timer_diff", 64'(tb_v - ta), 64'd5);

      // Single byte 0x55
      wr(A_TXDATA, 32'h0000_0055, 2'b00);
      chk("tx_before_pop", 64'(uart_tx), 64'd1);
      chk_rd("status_queued", A_STATUS, 32'h0000_0008);
      tick();
      for (int unsigned c = 0; c < FRAME; c++) begin
         chk($sformatf("tx55_c%0d", c), 64'(uart_tx), 64'(frame_bit(8'h55, c)));
         tick();
      end
      chk("tx55_idle", 64'(uart_tx), 64'd1);
      chk_rd("status_after_frame", A_STATUS, 32'h0000_0001);

      // Overflow: ten pushes on consecutive cycles, last one dropped
      for (int unsigned i = 0; i < 10; i++) begin
         bus.perip_addr  = A_TXDATA;
         bus.perip_wdata = 32'(i);
         bus.perip_mask  = 2'b00;
         bus.perip_wen   = 1'b1;
         tick();
         if (i >= 1) chk($sformatf("stream_c%0d", i - 1), 64'(uart_tx), 64'(stream_bit(i - 1)));
      end
      bus.perip_wen = 1'b0;
      chk_rd("status_overflow", A_STATUS, 32'h0000_000E);
      for (int unsigned c = 9; c < 9 * FRAME; c++) begin
         tick();
         chk($sformatf("stream_c%0d", c), 64'(uart_tx), 64'(stream_bit(c)));
      end
      tick();
      chk("stream_idle", 64'(uart_tx), 64'd1);
      chk_rd("status_drained", A_STATUS, 32'h0000_0005);
      wr(A_STATUS, 32'h0000_0004, 2'b10);
      chk_rd("status_ovf_clr", A_STATUS, 32'h0000_0001);

      // Timer carry from low to high word
      force dut.timer_q = 64'h0000_0000_FFFF_FFFF;
      release dut.timer_q;
      chk_rd("timer_pre_lo", A_TLO, 32'hFFFF_FFFF);
      chk_rd("timer_pre_hi", A_THI, 32'h0000_0000);
      tick();
      chk_rd("timer_wrap_lo", A_TLO, 32'h0000_0000);
      chk_rd("timer_wrap_hi", A_THI, 32'h0000_0001);

      // LED: word, then byte (upper byte of wdata must be ignored), then half
      wr(A_LED, 32'h0000_1234, 2'b10);
      chk("led_word", 64'(led), 64'h1234);
      wr(A_LED, 32'h0000_55AB, 2'b00);
      chk("led_byte", 64'(led), 64'h12AB);
      chk_rd("led_read", A_LED, 32'h0000_12AB);
      wr(A_LED, 32'hFFFF_BEEF, 2'b01);
      chk("led_half", 64'(led), 64'hBEEF);

      // Decode: DRAM pass-through
      bus.perip_addr  = 32'h8010_0004;
      bus.perip_wdata = 32'h1122_3344;
      bus.perip_mask  = 2'b10;
      bus.perip_wen   = 1'b1;
      #1;
      chk("dram_wen", 64'(bus.dram_wen), 64'd1);
      chk("dram_addr", 64'(bus.dram_addr), 64'h8010_0004);
      chk("dram_wdata", 64'(bus.dram_wdata), 64'h1122_3344);
      chk("dram_mask", 64'(bus.dram_mask), 64'd2);
      tick();

      // Decode: unmapped writes dropped, reads zero
      bus.perip_addr  = 32'h9000_0000;
      bus.perip_wdata = 32'h0000_0077;
      bus.perip_mask  = 2'b00;
      bus.perip_wen   = 1'b1;
      #1;
      chk("unmapped_dram_wen", 64'(bus.dram_wen), 64'd0);
      chk("unmapped_rdata", 64'(bus.perip_rdata), 64'h0);
      tick();
      bus.perip_addr  = 32'h9000_0010;
      bus.perip_wdata = 32'h0000_FFFF;
      bus.perip_mask  = 2'b10;
      tick();
      bus.perip_wen = 1'b0;
      chk("unmapped_led", 64'(led), 64'hBEEF);
      chk_rd("unmapped_status", A_STATUS, 32'h0000_0001);
      chk("unmapped_tx", 64'(uart_tx), 64'd1);

      // Read paths
      bus.dram_rdata = 32'hDEAD_BEEF;
      chk_rd("dram_read", 32'h8010_0008, 32'hDEAD_BEEF);
      chk_rd("mmio_hole", 32'h8020_0014, 32'h0);
      chk_rd("txdata_read", A_TXDATA, 32'h0);
      chk_rd("mmio_hole_1c", 32'h8020_001C, 32'h0);

      // Reset mid-frame aborts transmission and flushes the FIFO
      wr(A_TXDATA, 32'h0000_00A5, 2'b00);
      wr(A_TXDATA, 32'h0000_003C, 2'b00);
      chk("midframe_start", 64'(uart_tx), 64'd0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("midframe_rst_tx", 64'(uart_tx), 64'd1);
      chk("midframe_rst_led", 64'(led), 64'h0);
      chk_rd("midframe_rst_status", A_STATUS, 32'h0000_0001);
      bus.perip_addr = 32'h8010_0000;
      bus.perip_wen  = 1'b1;
      #1;
      chk("rst_dram_wen", 64'(bus.dram_wen), 64'd0);
      bus.perip_wen = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_rd("rerst_timer", A_TLO, 32'd0);
      repeat (2 * CLK_DIV) tick();
      chk("rerst_tx_idle", 64'(uart_tx), 64'd1);
      chk_rd("rerst_status", A_STATUS, 32'h0000_0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
